lif_neuron_core: RTL and testbench
==================================

# lif_neuron_core

Parametrised leaky integrate-and-fire neuron core. It accumulates signed synaptic weights from `NUM_IN` parallel input channels over a timestep. On each timestep strobe it applies a shift-based leak, adds the accumulated input, compares the result against a runtime threshold, and fires. After firing it holds the membrane at a reset level for a programmable number of refractory timesteps. It sits between the spike-routing/weight-lookup stage and the spike encoder of each NoC processing element, replacing the combinational single-input add/compare.

## Interface
- `WIDTH`, 32: membrane potential, weight and threshold width (signed, two's complement)
- `NUM_IN`, 4: number of parallel synaptic input channels
- `REFRAC_W`, 8: refractory counter width
- `clk` in 1: clock
- `rst_n` in 1: asynchronous, active-low reset
- `cfg_threshold` in WIDTH: firing threshold (signed)
- `cfg_v_reset` in WIDTH: potential loaded after a spike (signed)
- `cfg_decay_shift` in $clog2(WIDTH): leak shift; 0 means no leak
- `cfg_refrac` in REFRAC_W: refractory length in timesteps; 0 means none
- `in_valid` in NUM_IN: per-channel weight valid, one bit per channel
- `in_weight` in NUM_IN*WIDTH: packed signed weights; channel i is at [i*WIDTH +: WIDTH]
- `step` in 1: single-cycle timestep-close strobe
- `potential` out WIDTH: registered membrane potential
- `spike` out 1: registered one-cycle fire pulse
- `refractory` out 1: high while the neuron is in REFRACTORY

## Operation
- Internal accumulator `acc` (WIDTH, signed). Each cycle: `acc <= sat(acc + Σ valid weights)`.
- The sum is formed at WIDTH+$clog2(NUM_IN)+1 bits, then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- States: INTEGRATE (reset state) and REFRACTORY.
- INTEGRATE, on `step`:
  - `leak = (cfg_decay_shift==0) ? 0 : potential >>> cfg_decay_shift` (arithmetic shift).
  - `v_next = sat(potential − leak + acc_total)`, where `acc_total` includes weights valid in the `step` cycle itself.
  - If `v_next >= cfg_threshold` (signed compare): `spike<=1`, `potential<=cfg_v_reset`, `acc<=0`. If `cfg_refrac!=0`, load `rcnt<=cfg_refrac` and go to REFRACTORY.
  - Otherwise: `potential<=v_next`, `acc<=0`.
- REFRACTORY: incoming weights are discarded and `acc` is held at 0.
  - On each `step`, `rcnt` decrements. When it reaches 0, return to INTEGRATE.
  - `potential` is held at `cfg_v_reset`.
- `refractory` is high exactly while in REFRACTORY.
- Config inputs are sampled only in the `step` cycle. Changes between steps have no effect until the next step.
- Without `step`, `potential` and `spike` hold their values, except that `spike` clears after one cycle.

## Timing
- Reset (asynchronous, any time, including mid-refractory): `potential=0`, `spike=0`, `refractory=0`, `acc=0`, `rcnt=0`, state INTEGRATE.
- Latency: `potential`, `spike` and `refractory` update on the rising edge that samples `step`, visible the next cycle.
- `spike` is high for exactly one cycle per firing.
- Back-to-back `step` pulses on consecutive cycles are legal; each is a full timestep.
- An input with `in_valid` high in the cycle after `step` belongs to the new timestep.
- With `cfg_refrac=N`, the neuron ignores input for N full timesteps after the spike step. It integrates again starting with the (N+1)th step.
- Saturation applies both in the accumulator and in `v_next`. There is no wrap-around.

## Structure
- Package `neuron_pkg`:
  - state enum `neuron_state_t` (INTEGRATE, REFRACTORY)
  - `sat_to_width` function
  - localparams `POT_MAX` and `POT_MIN`
- Sub-module `synapse_sum`: combinational masked adder of the NUM_IN channels with a widened saturating output. It is instantiated once.
- The FSM, leak, compare and refractory counter live in `lif_neuron_core`.

## Test plan
All scenarios use WIDTH=32, NUM_IN=4 and `cfg_v_reset=0` unless stated.
- Reset: assert `rst_n=0` mid-run → `potential=0`, `spike=0`, `refractory=0` immediately (asynchronous). The first step after release with ch0=5 gives `potential=5`.
- Integrate/fire, no leak (shift=0, threshold=100):
  - step with ch0=30, ch1=20 → `potential=50`, `spike=0`.
  - next step with ch2=60 → `spike=1` for one cycle, `potential=0`.
- Leak (shift=1, threshold=1000): from `potential=80`, steps with no input → 40, then 20, then 10. From −80 → −40.
- Refractory (`cfg_refrac=2`, threshold=100): fire, then 2 steps with ch0=200 → `potential=0`, `refractory=1`, no spike. The third step with ch0=50 → `potential=50`, `refractory=0`.
- Multi-cycle accumulation: ch0=10 on 3 cycles plus ch1=7 in the `step` cycle → `potential=37`.
- Saturation: all 4 channels at 0x7FFFFFFF → `potential=0x7FFFFFFF`. All at 0x80000000 with `potential` starting at −1 → `potential=0x80000000`. No wrap in either case.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types, bounds and the saturation helper for the LIF neuron core.
package neuron_pkg;

   // Neuron operating states
   typedef enum logic [0:0] {
      INTEGRATE  = 1'b0,
      REFRACTORY = 1'b1
   } neuron_state_t;

   // Default membrane width and its signed limits
   localparam int POT_W = 32;
   localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
   localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

   // Working width for the generic saturation helper; callers sign-extend into it
   localparam int SAT_W = 72;

   // Clamp a signed value to the range representable in w bits (w < SAT_W)
   function automatic logic signed [SAT_W-1:0] sat_to_width(
      input logic signed [SAT_W-1:0] val,
      input int                      w
   );
      logic signed [SAT_W-1:0] one_v;
      logic signed [SAT_W-1:0] hi_v;
      logic signed [SAT_W-1:0] lo_v;
      one_v = {{(SAT_W-1){1'b0}}, 1'b1};
      hi_v  = (one_v <<< (w - 1)) - one_v;
      lo_v  = ~hi_v;
      if (val > hi_v) begin
         sat_to_width = hi_v;
      end else if (val < lo_v) begin
         sat_to_width = lo_v;
      end else begin
         sat_to_width = val;
      end
   endfunction

endpackage

// File: rtl/synapse_sum.sv
// Masked adder: base plus every valid synaptic weight, formed wide and
// saturated back to WIDTH bits.
module synapse_sum
   import neuron_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4
)
(
   input  logic [NUM_IN-1:0]        in_valid,
   input  logic [NUM_IN*WIDTH-1:0]  in_weight,
   input  logic signed [WIDTH-1:0]  base,
   output logic signed [WIDTH-1:0]  sum_sat
);

   // One guard bit per doubling of channels plus one for the base addend
   localparam int SUM_W = WIDTH + $clog2(NUM_IN) + 1;

   logic signed [SUM_W-1:0] sum_wide_s;
   logic signed [WIDTH-1:0] wt_s;

   // Add the base and the valid channels at full width, then clamp
   always_comb begin
      sum_wide_s = SUM_W'(base);
      wt_s       = {WIDTH{1'b0}};
      for (int i = 0; i < NUM_IN; i++) begin
         wt_s = in_weight[i*WIDTH +: WIDTH];
         if (in_valid[i]) begin
            sum_wide_s = sum_wide_s + SUM_W'(wt_s);
         end else begin
            sum_wide_s = sum_wide_s;
         end
      end
      sum_sat = WIDTH'(sat_to_width(SAT_W'(sum_wide_s), WIDTH));
   end

endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: accumulates weights over a timestep, then
// on each step strobe applies leak, integrates, fires and runs refractory time.
module lif_neuron_core
   import neuron_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int NUM_IN   = 4,
   parameter int REFRAC_W = 8
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic signed [WIDTH-1:0]    cfg_threshold,
   input  logic signed [WIDTH-1:0]    cfg_v_reset,
   input  logic [$clog2(WIDTH)-1:0]   cfg_decay_shift,
   input  logic [REFRAC_W-1:0]        cfg_refrac,
   input  logic [NUM_IN-1:0]          in_valid,
   input  logic [NUM_IN*WIDTH-1:0]    in_weight,
   input  logic                       step,
   output logic signed [WIDTH-1:0]    potential,
   output logic                       spike,
   output logic                       refractory
);

   // Two extra bits cover potential - leak + acc_total without overflow
   localparam int VW = WIDTH + 2;
   localparam logic [REFRAC_W-1:0] RCNT_ONE = {{(REFRAC_W-1){1'b0}}, 1'b1};

   neuron_state_t           state_r;
   logic signed [WIDTH-1:0] acc_r;
   logic [REFRAC_W-1:0]     rcnt_r;

   logic signed [WIDTH-1:0] acc_total_s;
   logic signed [WIDTH-1:0] leak_s;
   logic signed [VW-1:0]    v_wide_s;
   logic signed [WIDTH-1:0] v_next_s;
   logic                    fire_s;

   // Accumulator plus this cycle's valid weights, saturated
   synapse_sum #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_synapse_sum (
      .in_valid  (in_valid),
      .in_weight (in_weight),
      .base      (acc_r),
      .sum_sat   (acc_total_s)
   );

   // Leak, candidate membrane value and threshold compare for the step cycle
   always_comb begin
      if (cfg_decay_shift == {$clog2(WIDTH){1'b0}}) begin
         leak_s = {WIDTH{1'b0}};
      end else begin
         leak_s = potential >>> cfg_decay_shift;
      end
      v_wide_s = VW'(potential) - VW'(leak_s) + VW'(acc_total_s);
      v_next_s = WIDTH'(sat_to_width(SAT_W'(v_wide_s), WIDTH));
      fire_s   = (v_next_s >= cfg_threshold);
   end

   // Neuron FSM: integration, firing, refractory countdown and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= INTEGRATE;
         acc_r      <= {WIDTH{1'b0}};
         rcnt_r     <= {REFRAC_W{1'b0}};
         potential  <= {WIDTH{1'b0}};
         spike      <= 1'b0;
         refractory <= 1'b0;
      end else begin
         spike <= 1'b0;
         case (state_r)
            INTEGRATE: begin
               if (step) begin
                  acc_r <= {WIDTH{1'b0}};
                  if (fire_s) begin
                     spike     <= 1'b1;
                     potential <= cfg_v_reset;
                     if (cfg_refrac != {REFRAC_W{1'b0}}) begin
                        rcnt_r     <= cfg_refrac;
                        state_r    <= REFRACTORY;
                        refractory <= 1'b1;
                     end else begin
                        rcnt_r     <= {REFRAC_W{1'b0}};
                        state_r    <= INTEGRATE;
                        refractory <= 1'b0;
                     end
                  end else begin
                     potential <= v_next_s;
                  end
               end else begin
                  acc_r <= acc_total_s;
               end
            end
            REFRACTORY: begin
               // Input arriving during refractory time is dropped
               acc_r <= {WIDTH{1'b0}};
               if (step) begin
                  rcnt_r <= rcnt_r - RCNT_ONE;
                  if (rcnt_r <= RCNT_ONE) begin
                     state_r    <= INTEGRATE;
                     refractory <= 1'b0;
                  end else begin
                     state_r    <= REFRACTORY;
                     refractory <= 1'b1;
                  end
               end else begin
                  rcnt_r <= rcnt_r;
               end
            end
            default: begin
               state_r    <= INTEGRATE;
               acc_r      <= {WIDTH{1'b0}};
               rcnt_r     <= {REFRAC_W{1'b0}};
               refractory <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed, table-driven bench for lif_neuron_core with a few hand sequences.
module tb_lif_neuron_core;
   import neuron_pkg::*;

   localparam int WIDTH    = 32;
   localparam int NUM_IN   = 4;
   localparam int REFRAC_W = 8;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic signed [WIDTH-1:0]   cfg_threshold;
   logic signed [WIDTH-1:0]   cfg_v_reset;
   logic [4:0]                cfg_decay_shift;
   logic [REFRAC_W-1:0]       cfg_refrac;
   logic [NUM_IN-1:0]         in_valid;
   logic [NUM_IN*WIDTH-1:0]   in_weight;
   logic                      step;
   logic signed [WIDTH-1:0]   potential;
   logic                      spike;
   logic                      refractory;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      string       name;
      logic [3:0]  valid;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      logic [31:0] w3;
      logic [31:0] thr;
      logic [4:0]  shift;
      logic [7:0]  refrac;
      logic [31:0] vreset;
      logic [31:0] exp_pot;
      logic        exp_spike;
      logic        exp_refr;
   } vec_t;

   vec_t vecs[21];

   always #5 clk = ~clk;

   lif_neuron_core #(
      .WIDTH    (WIDTH),
      .NUM_IN   (NUM_IN),
      .REFRAC_W (REFRAC_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cfg_threshold   (cfg_threshold),
      .cfg_v_reset     (cfg_v_reset),
      .cfg_decay_shift (cfg_decay_shift),
      .cfg_refrac      (cfg_refrac),
      .in_valid        (in_valid),
      .in_weight       (in_weight),
      .step            (step),
      .potential       (potential),
      .spike           (spike),
      .refractory      (refractory)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // Drive one step with the vector's inputs and config; returns at the
   // negedge after the sampling edge with step and inputs cleared.
   task automatic apply_step(input vec_t v);
      @(negedge clk);
      cfg_threshold   = v.thr;
      cfg_v_reset     = v.vreset;
      cfg_decay_shift = v.shift;
      cfg_refrac      = v.refrac;
      in_valid        = v.valid;
      in_weight       = {v.w3, v.w2, v.w1, v.w0};
      step            = 1'b1;
      @(negedge clk);
      step            = 1'b0;
      in_valid        = 4'b0000;
   endtask

   initial begin
      rst_n           = 1'b0;
      step            = 1'b0;
      in_valid        = 4'b0000;
      in_weight       = {(NUM_IN*WIDTH){1'b0}};
      cfg_threshold   = 32'd100;
      cfg_v_reset     = 32'd0;
      cfg_decay_shift = 5'd0;
      cfg_refrac      = 8'd0;

      //            name            valid    w0             w1         w2         w3         thr            sh    rf    vreset         exp_pot        spk   refr
      vecs[0]  = '{"int_50",       4'b0011, 32'd30,        32'd20,    32'd0,     32'd0,     32'd100,       5'd0, 8'd0, 32'd0,         32'd50,        1'b0, 1'b0};
      vecs[1]  = '{"fire_60",      4'b0100, 32'd0,         32'd0,     32'd60,    32'd0,     32'd100,       5'd0, 8'd0, 32'd0,         32'd0,         1'b1, 1'b0};
      vecs[2]  = '{"leak_load",    4'b0001, 32'd80,        32'd0,     32'd0,     32'd0,     32'd1000,      5'd0, 8'd0, 32'd0,         32'd80,        1'b0, 1'b0};
      vecs[3]  = '{"leak_40",      4'b0000, 32'd0,         32'd0,     32'd0,     32'd0,     32'd1000,      5'd1, 8'd0, 32'd0,         32'd40,        1'b0, 1'b0};
      vecs[4]  = '{"leak_20",      4'b0000, 32'd0,         32'd0,     32'd0,     32'd0,     32'd1000,      5'd1, 8'd0, 32'd0,         32'd20,        1'b0, 1'b0};
      vecs[5]  = '{"leak_10",      4'b0000, 32'd0,         32'd0,     32'd0,     32'd0,     32'd1000,      5'd1, 8'd0, 32'd0,         32'd10,        1'b0, 1'b0};
      vecs[6]  = '{"neg_load",     4'b0001, 32'hFFFF_FFA6, 32'd0,     32'd0,     32'd0,     32'd1000,      5'd0, 8'd0, 32'd0,         32'hFFFF_FFB0, 1'b0, 1'b0};
      vecs[7]  = '{"neg_leak",     4'b0000, 32'd0,         32'd0,     32'd0,     32'd0,     32'd1000,      5'd1, 8'd0, 32'd0,         32'hFFFF_FFD8, 1'b0, 1'b0};
      vecs[8]  = '{"to_zero",      4'b0001, 32'd40,        32'd0,     32'd0,     32'd0,     32'd1000,      5'd0, 8'd0, 32'd0,         32'd0,         1'b0, 1'b0};
      vecs[9]  = '{"refr_fire",    4'b0001, 32'd150,       32'd0,     32'd0,     32'd0,     32'd100,       5'd0, 8'd2, 32'd0,         32'd0,         1'b1, 1'b1};
      vecs[10] = '{"refr_1",       4'b0001, 32'd200,       32'd0,     32'd0,     32'd0,     32'd100,       5'd0, 8'd2, 32'd0,         32'd0,         1'b0, 1'b1};
      vecs[11] = '{"refr_2",       4'b0001, 32'd200,       32'd0,     32'd0,     32'd0,     32'd100,       5'd0, 8'd2, 32'd0,         32'd0,         1'b0, 1'b0};
      vecs[12] = '{"refr_back",    4'b0001, 32'd50,        32'd0,     32'd0,     32'd0,     32'd100,       5'd0, 8'd2, 32'd0,         32'd50,        1'b0, 1'b0};
      vecs[13] = '{"exact_thr",    4'b0001, 32'd50,        32'd0,     32'd0,     32'd0,     32'd100,       5'd0, 8'd0, 32'd0,         32'd0,         1'b1, 1'b0};
      vecs[14] = '{"below_thr",    4'b0001, 32'd99,        32'd0,     32'd0,     32'd0,     32'd100,       5'd0, 8'd0, 32'd0,         32'd99,        1'b0, 1'b0};
      vecs[15] = '{"sat_pos",      4'b1111, POT_MAX,       POT_MAX,   POT_MAX,   POT_MAX,   POT_MAX,       5'd0, 8'd0, POT_MAX,       POT_MAX,       1'b1, 1'b0};
      vecs[16] = '{"sat_neg_prep", 4'b0001, POT_MIN,       32'd0,     32'd0,     32'd0,     32'd1000,      5'd0, 8'd0, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[17] = '{"sat_neg",      4'b1111, POT_MIN,       POT_MIN,   POT_MIN,   POT_MIN,   32'd1000,      5'd0, 8'd0, 32'd0,         POT_MIN,       1'b0, 1'b0};
      vecs[18] = '{"recover",      4'b0001, 32'd5,         32'd0,     32'd0,     32'd0,     32'd1000,      5'd0, 8'd0, 32'd0,         32'h8000_0005, 1'b0, 1'b0};
      vecs[19] = '{"negthr_below", 4'b0001, 32'h7FFF_FFF0, 32'd0,     32'd0,     32'd0,     32'hFFFF_FFF6, 5'd0, 8'd0, 32'd0,         32'hFFFF_FFF5, 1'b0, 1'b0};
      vecs[20] = '{"negthr_fire",  4'b0001, 32'd1,         32'd0,     32'd0,     32'd0,     32'hFFFF_FFF6, 5'd0, 8'd0, 32'd0,         32'd0,         1'b1, 1'b0};

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_potential",  potential,        32'd0);
      check("rst_spike",      32'(spike),       32'd0);
      check("rst_refractory", 32'(refractory),  32'd0);
      rst_n = 1'b1;

      // Table: one step per vector, then one idle cycle checking the hold
      for (int i = 0; i < 21; i++) begin
         apply_step(vecs[i]);
         check({vecs[i].name, "_pot"},   potential,       vecs[i].exp_pot);
         check({vecs[i].name, "_spike"}, 32'(spike),      32'(vecs[i].exp_spike));
         check({vecs[i].name, "_refr"},  32'(refractory), 32'(vecs[i].exp_refr));
         @(negedge clk);
         check({vecs[i].name, "_hold_pot"},   potential,       vecs[i].exp_pot);
         check({vecs[i].name, "_hold_spike"}, 32'(spike),      32'd0);
         check({vecs[i].name, "_hold_refr"},  32'(refractory), 32'(vecs[i].exp_refr));
      end

      // Asynchronous reset while spiking and entering refractory
      apply_step('{"arst_fire", 4'b0001, 32'd200, 32'd0, 32'd0, 32'd0, 32'd100, 5'd0, 8'd3, 32'd77, 32'd77, 1'b1, 1'b1});
      check("arst_pre_pot",   potential,       32'd77);
      check("arst_pre_spike", 32'(spike),      32'd1);
      check("arst_pre_refr",  32'(refractory), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_pot",   potential,       32'd0);
      check("arst_spike", 32'(spike),      32'd0);
      check("arst_refr",  32'(refractory), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_step('{"post_rst", 4'b0001, 32'd5, 32'd0, 32'd0, 32'd0, 32'd100, 5'd0, 8'd0, 32'd0, 32'd5, 1'b0, 1'b0});
      check("post_rst_pot",  potential,       32'd5);
      check("post_rst_refr", 32'(refractory), 32'd0);

      // Multi-cycle accumulation: three cycles of ch0=10, ch1=7 in the step cycle
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      in_weight = {32'd0, 32'd0, 32'd7, 32'd10};
      for (int c = 0; c < 3; c++) begin
         in_valid = 4'b0001;
         @(negedge clk);
      end
      check("acc_no_step_pot", potential, 32'd0);
      in_valid = 4'b0010;
      step     = 1'b1;
      @(negedge clk);
      step     = 1'b0;
      in_valid = 4'b0000;
      check("multi_acc_pot",   potential,  32'd37);
      check("multi_acc_spike", 32'(spike), 32'd0);

      // Back-to-back steps; input in the cycle after a step is the new timestep
      @(negedge clk);
      in_valid  = 4'b0001;
      in_weight = {32'd0, 32'd0, 32'd0, 32'd3};
      step      = 1'b1;
      @(negedge clk);
      check("b2b_first_pot", potential, 32'd40);
      in_weight = {32'd0, 32'd0, 32'd0, 32'd4};
      @(negedge clk);
      step     = 1'b0;
      in_valid = 4'b0000;
      check("b2b_second_pot",   potential,  32'd44);
      check("b2b_second_spike", 32'(spike), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
